if_fetch_stage: RTL

Instruction-fetch stage. Sits directly upstream of the register-decode stage in the 5-stage pipeline.
- Generates sequential fetch addresses and fetches instructions over a req/ack memory handshake.
- Buffers fetched instructions in a small prefetch FIFO.
- Presents {instruction, PC+4} to decode with valid/stall flow control.
- Flushes and restarts on a branch/jump redirect from decode.

---
 rtl/if_pkg.sv | 23 ++
 rtl/if_fetch_stage_fifo.sv | 52 +++++
 rtl/if_fetch_stage.sv | 133 +++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [INSTR_W-1:0] pcp4;
  } fifo_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] addr);
    return {addr[INSTR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_stage_fifo.sv
// Prefetch buffer: DEPTH-entry circular FIFO with synchronous flush.
module fetch_fifo
  import if_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  fifo_entry_t       wdata,
  output fifo_entry_t       head,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  fifo_entry_t            mem [DEPTH];
  logic [PTR_W-1:0]       wptr;
  logic [PTR_W-1:0]       rptr;

  // Pointer and occupancy update; flush discards everything including same-cycle push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Storage array; contents are don't-care until written, reads are gated by count.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr] <= wdata;
  end

  assign head  = mem[rptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: sequential fetch over req/ack, prefetch buffering, redirect flush.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter int unsigned         DEPTH    = 4,
  parameter logic [INSTR_W-1:0]  RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                Clk,
  input  logic                Rst,
  output logic                MemReq,
  output logic [INSTR_W-1:0]  MemAddr,
  input  logic                MemAck,
  input  logic [INSTR_W-1:0]  MemData,
  input  logic                Redirect,
  input  logic [INSTR_W-1:0]  RedirectPC,
  input  logic                Stall,
  output logic                InstValid,
  output logic [INSTR_W-1:0]  Instruction,
  output logic [INSTR_W-1:0]  InstPCP4
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t        state;
  fetch_state_t        state_n;
  logic [INSTR_W-1:0]  fetch_pc;
  logic [INSTR_W-1:0]  fetch_pc_n;
  logic [INSTR_W-1:0]  mem_addr_n;
  logic                mem_req_n;
  logic [INSTR_W-1:0]  redirect_pc;

  logic                push;
  logic                pop;
  logic                issue_ok;
  fifo_entry_t         wdata;
  fifo_entry_t         head;
  logic [CNT_W-1:0]    count;
  logic                full;
  logic                empty;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (Clk),
    .rst   (Rst),
    .push  (push),
    .pop   (pop),
    .flush (Redirect),
    .wdata (wdata),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Flow-control terms; a redirect suppresses both FIFO ports.
  assign redirect_pc = word_align(RedirectPC);
  assign push        = (state == WAIT) && MemAck && !Redirect;
  assign InstValid   = !empty && !Redirect;
  assign pop         = InstValid && !Stall;
  assign wdata       = '{instr: MemData, pcp4: MemAddr + 32'd4};

  // Room for one more request after this cycle's push/pop (slot is reserved at issue).
  always_comb begin
    issue_ok = 1'b0;
    if (!push)    issue_ok = !full || pop;
    else if (pop) issue_ok = !full;
    else          issue_ok = (count < CNT_W'(DEPTH - 1));
  end

  // Head of FIFO to decode, forced to zero when nothing is buffered.
  assign Instruction = empty ? '0 : head.instr;
  assign InstPCP4    = empty ? '0 : head.pcp4;

  // State, fetch PC and registered memory request.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      MemReq   <= 1'b0;
      MemAddr  <= RESET_PC;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      MemReq   <= mem_req_n;
      MemAddr  <= mem_addr_n;
    end
  end

  // Next-state logic; redirect dominates, and an issued request is never withdrawn.
  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    mem_req_n  = MemReq;
    mem_addr_n = MemAddr;
    unique case (state)
      IDLE: begin
        if (Redirect) begin
          fetch_pc_n = redirect_pc;
        end else if (issue_ok) begin
          state_n    = WAIT;
          mem_req_n  = 1'b1;
          mem_addr_n = fetch_pc;
        end
      end
      WAIT: begin
        if (Redirect) begin
          state_n    = DRAIN;
          fetch_pc_n = redirect_pc;
        end else if (MemAck) begin
          fetch_pc_n = fetch_pc + 32'd4;
          if (issue_ok) begin
            mem_addr_n = fetch_pc + 32'd4;
          end else begin
            state_n   = IDLE;
            mem_req_n = 1'b0;
          end
        end
      end
      DRAIN: begin
        if (Redirect) begin
          fetch_pc_n = redirect_pc;
        end else if (MemAck) begin
          state_n   = IDLE;
          mem_req_n = 1'b0;
        end
      end
      default: begin
        state_n   = IDLE;
        mem_req_n = 1'b0;
      end
    endcase
  end

endmodule
